fb_capture_ctrl: RTL and testbench

Sequencer and read arbiter for the camera frame buffer (4096 × 8-bit, write port plus a registered-address read port). It turns the camera's vsync/href/pixel stream into windowed write addresses and frames the capture with an arm/done handshake. It also shares the single read port between two requesters: the display path (port 0) and the laser-tracking logic (port 1). It sits between the camera interface and the frame buffer instance.

---
 rtl/fb_capture_ctrl_pkg.sv | 11 +
 rtl/fb_capture_ctrl_arb.sv | 41 ++++
 rtl/fb_capture_ctrl.sv | 124 ++++++++++++
 tb/tb_fb_capture_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_capture_ctrl_pkg.sv
// fb_capture_ctrl_pkg: shared capture FSM state encodings and frame buffer geometry defaults.
package fb_capture_ctrl_pkg;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_WAIT_VS = 2'd1;
    localparam state_t S_CAPTURE = 2'd2;
    localparam state_t S_DONE    = 2'd3;
    localparam int IMG_W_DEF = 64;
    localparam int IMG_H_DEF = 64;
    localparam int FB_DEPTH  = 4096;
endpackage

// File: rtl/fb_capture_ctrl_arb.sv
// fb_rr_arb2: two-way round-robin arbiter for the frame buffer read port with registered return steering.
// Ports: clk/rst; reqN/addrN in, gntN (combinational) out, validN/dataN out one cycle after gntN;
// rd_addr drives the frame buffer, rd_data returns from it one cycle later.
module fb_rr_arb2 #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              valid0,
    output logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              valid1,
    output logic [DATA_W-1:0] data1,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);
    // ptr names the port that lost the last contested grant; it wins the next contest
    logic ptr;
    assign gnt0    = req0 & (~req1 | ~ptr);
    assign gnt1    = req1 & (~req0 | ptr);
    assign rd_addr = gnt1 ? addr1 : (gnt0 ? addr0 : '0);
    assign data0   = valid0 ? rd_data : '0;
    assign data1   = valid1 ? rd_data : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= 1'b0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
        end else begin
            valid0 <= gnt0;
            valid1 <= gnt1;
            if (req0 & req1) ptr <= gnt0;
        end
    end
endmodule

// File: rtl/fb_capture_ctrl.sv
// fb_capture_ctrl: camera capture sequencer (windowed frame buffer writes, arm/done handshake) plus shared read port.
// Ports: clk/rst; arm, cont, vsync, href, pix_valid, pix_data from control/camera;
// wr_en/wr_addr/wr_data and rd_addr/rd_data to the frame buffer; rdN_req/addr/gnt/valid/data for two readers;
// busy, frame_done, clipped status.
module fb_capture_ctrl
    import fb_capture_ctrl_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              cont,
    input  logic              vsync,
    input  logic              href,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_gnt,
    output logic              rd0_valid,
    output logic [DATA_W-1:0] rd0_data,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_gnt,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd1_data,
    output logic              busy,
    output logic              frame_done,
    output logic              clipped
);
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0]     COL_END   = CW'(IMG_W);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

    state_t            state;
    logic              vsync_q, href_q;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] line_base;
    logic              vs_rise, href_fall, pix_in, in_win;

    assign vs_rise    = vsync & ~vsync_q;
    assign href_fall  = href_q & ~href;
    assign pix_in     = (state == S_CAPTURE) & pix_valid & href;
    assign in_win     = col < COL_END;
    assign busy       = state != S_IDLE;
    assign frame_done = state == S_DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            col       <= '0;
            row       <= '0;
            line_base <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            clipped   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
            wr_en   <= pix_in & in_win;
            // col stops at IMG_W so every later pixel on the line is counted as clipped
            if (pix_in & in_win) begin
                wr_addr <= line_base + ADDR_W'(col);
                wr_data <= pix_data;
                col     <= col + 1'b1;
            end
            if (pix_in & ~in_win) clipped <= 1'b1;
            case (state)
                S_IDLE: if (arm) begin
                    state   <= S_WAIT_VS;
                    clipped <= 1'b0;
                end
                S_WAIT_VS: if (vs_rise) begin
                    state     <= S_CAPTURE;
                    row       <= '0;
                    col       <= '0;
                    line_base <= '0;
                end
                S_CAPTURE: begin
                    // href is low on a falling edge, so no pixel competes with the row advance
                    if (href_fall) begin
                        row       <= row + 1'b1;
                        line_base <= line_base + LINE_STEP;
                        col       <= '0;
                    end
                    if (vs_rise || (href_fall && row == ROW_LAST)) state <= S_DONE;
                end
                default: state <= cont ? S_WAIT_VS : S_IDLE;
            endcase
        end
    end

    fb_rr_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (rd0_req),
        .addr0  (rd0_addr),
        .gnt0   (rd0_gnt),
        .valid0 (rd0_valid),
        .data0  (rd0_data),
        .req1   (rd1_req),
        .addr1  (rd1_addr),
        .gnt1   (rd1_gnt),
        .valid1 (rd1_valid),
        .data1  (rd1_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );
endmodule

// File: tb/tb_fb_capture_ctrl.sv
// tb_fb_capture_ctrl: scoreboard bench for fb_capture_ctrl with a behavioural frame buffer.
module tb_fb_capture_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, arm, cont, vsync, href, pix_valid;
    logic [7:0] pix_data, wr_data, rd_data, rd0_data, rd1_data;
    logic [14:0] wr_addr, rd_addr, rd0_addr, rd1_addr;
    logic wr_en, rd0_req, rd0_gnt, rd0_valid, rd1_req, rd1_gnt, rd1_valid, busy, frame_done, clipped;

    fb_capture_ctrl dut (
        .clk(clk), .rst(rst), .arm(arm), .cont(cont), .vsync(vsync), .href(href),
        .pix_valid(pix_valid), .pix_data(pix_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt), .rd0_valid(rd0_valid), .rd0_data(rd0_data),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt), .rd1_valid(rd1_valid), .rd1_data(rd1_data),
        .busy(busy), .frame_done(frame_done), .clipped(clipped)
    );

    logic [7:0] mem [4096];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr[11:0]] <= wr_data;
        rd_data <= mem[rd_addr[11:0]];
    end

    typedef struct { logic [14:0] a; logic [7:0] d; } wr_t;
    typedef struct { int p; logic [7:0] d; } rd_t;
    wr_t wq[$];
    rd_t rq[$];
    wr_t we;
    rd_t re;
    int checks = 0, errors = 0, wr_cnt = 0, fd_cnt = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected got addr %0d data %0h want no write", wr_addr, wr_data);
            end else begin
                we = wq.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(we.a));
                chk("wr_data", 32'(wr_data), 32'(we.d));
            end
        end
        if (rd0_valid | rd1_valid) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected got valid %b%b want none", rd1_valid, rd0_valid);
            end else begin
                re = rq.pop_front();
                chk("rd_port", 32'({rd1_valid, rd0_valid}), re.p == 1 ? 32'd2 : 32'd1);
                chk("rd_data", 32'(rd1_valid ? rd1_data : rd0_data), 32'(re.d));
            end
        end
        if (frame_done) fd_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        cyc();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic send_line(input int r, input int n, input bit exp);
        for (int c = 0; c < n; c++) begin
            cyc();
            href = 1'b1;
            pix_valid = 1'b1;
            pix_data = 8'(r ^ c);
            if (exp && c < 64) wq.push_back('{a: 15'(r * 64 + c), d: 8'(r ^ c)});
        end
        cyc();
        href = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        cyc();
    endtask

    task automatic wait_fd(input int target);
        int n = 0;
        while (fd_cnt < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("frame_done_cnt", 32'(fd_cnt), 32'(target));
    endtask

    task automatic rd_step(input int p);
        @(negedge clk);
        chk("gnt0", 32'(rd0_gnt), 32'(p == 0));
        chk("gnt1", 32'(rd1_gnt), 32'(p == 1));
        rq.push_back('{p: p, d: p == 1 ? 8'd9 : 8'd5});
        cyc();
    endtask

    int w0;
    initial begin
        rst = 1'b1; arm = 0; cont = 0; vsync = 0; href = 0; pix_valid = 0; pix_data = 0;
        rd0_req = 0; rd1_req = 0; rd0_addr = 0; rd1_addr = 0;
        repeat (3) cyc();
        chk("rst_flags", 32'({wr_en, busy, frame_done, clipped, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid}), 0);
        chk("rst_wr", 32'({wr_addr, wr_data}), 0);
        chk("rst_rd", 32'({rd_addr, rd0_data, rd1_data}), 0);
        rst = 1'b0;
        cyc();

        // full 64x64 frame
        pulse_arm();
        chk("busy_armed", 32'(busy), 1);
        w0 = wr_cnt;
        cyc(); vsync = 1'b1; cyc(); cyc(); vsync = 1'b0;
        for (int r = 0; r < 64; r++) send_line(r, 64, 1);
        wait_fd(1);
        @(negedge clk);
        chk("busy_after_frame", 32'(busy), 0);
        chk("fd_one_cycle", 32'(frame_done), 0);
        chk("frame_writes", 32'(wr_cnt - w0), 4096);
        chk("wq_empty_frame", 32'(wq.size()), 0);

        // read arbitration
        cyc();
        rd0_req = 1; rd0_addr = 15'd5; rd1_req = 1; rd1_addr = 15'd9;
        for (int k = 0; k < 4; k++) rd_step(k % 2);
        rd1_req = 0;
        rd_step(0);
        rd1_req = 1;
        rd_step(0);
        rd0_req = 0; rd1_req = 0;
        cyc(); cyc();
        chk("rq_empty", 32'(rq.size()), 0);

        // short frame with 70-pixel lines
        pulse_arm();
        w0 = wr_cnt;
        cyc(); vsync = 1'b1; cyc(); cyc(); vsync = 1'b0;
        for (int r = 0; r < 10; r++) send_line(r, 70, 1);
        chk("clipped_set", 32'(clipped), 1);
        cyc(); vsync = 1'b1;
        wait_fd(2);
        @(negedge clk);
        chk("busy_after_short", 32'(busy), 0);
        chk("short_writes", 32'(wr_cnt - w0), 640);
        chk("clipped_sticky", 32'(clipped), 1);

        // arm with vsync still high, continuous mode
        cont = 1'b1;
        pulse_arm();
        chk("clipped_cleared", 32'(clipped), 0);
        chk("busy_wait_vs", 32'(busy), 1);
        w0 = wr_cnt;
        send_line(0, 8, 0);
        cyc(); cyc();
        chk("no_write_vs_high", 32'(wr_cnt - w0), 0);
        vsync = 1'b0; cyc(); cyc(); vsync = 1'b1;
        send_line(0, 64, 1);
        send_line(1, 64, 1);
        vsync = 1'b0; cyc(); vsync = 1'b1;
        wait_fd(3);
        @(negedge clk);
        chk("cont_rearm_busy", 32'(busy), 1);
        chk("cont_writes", 32'(wr_cnt - w0), 128);

        // reset in the middle of row 20
        cont = 1'b0;
        vsync = 1'b0; cyc(); cyc(); vsync = 1'b1;
        for (int r = 0; r < 20; r++) send_line(r, 64, 1);
        for (int c = 0; c < 10; c++) begin
            cyc();
            href = 1'b1; pix_valid = 1'b1; pix_data = 8'(20 ^ c);
            wq.push_back('{a: 15'(20 * 64 + c), d: 8'(20 ^ c)});
        end
        cyc();
        rst = 1'b1; href = 1'b0; pix_valid = 1'b0; vsync = 1'b0;
        cyc();
        chk("mid_rst_flags", 32'({wr_en, busy, frame_done, clipped, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid}), 0);
        chk("mid_rst_wr", 32'({wr_addr, wr_data}), 0);
        chk("wq_empty_rst", 32'(wq.size()), 0);
        rst = 1'b0;
        repeat (3) cyc();
        chk("no_fd_on_rst", 32'(fd_cnt), 3);

        // fresh capture restarts at address 0
        pulse_arm();
        cyc(); vsync = 1'b1;
        send_line(0, 5, 1);
        vsync = 1'b0; cyc(); vsync = 1'b1;
        wait_fd(4);
        cyc(); cyc();
        chk("wq_empty_end", 32'(wq.size()), 0);
        chk("rq_empty_end", 32'(rq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
